// File: rtl/ldvio_writer_pkg.sv
// Shared load/store-queue types for the load-violation flag writer.
package ldvio_writer_pkg;
    localparam int LQ_DEPTH   = 16;
    localparam int LQ_INDEX   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int MATCH_LSB  = 2;

    typedef logic [LQ_DEPTH-1:0] lqVector_t;
    typedef logic [LQ_INDEX-1:0] lqIdx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } ldvio_state_t;
endpackage

// File: rtl/ldvio_writer_if.sv
// Store-search handshake and flag-RAM write port of the load-violation writer.
interface ldvio_writer_if;
    import ldvio_writer_pkg::*;

    logic                  st_valid_i;
    logic                  st_ready_o;
    logic [ADDR_WIDTH-1:0] st_addr_i;
    lqIdx_t                st_age_idx_i;
    lqIdx_t                ldvio_addr_o;
    logic                  ldvio_data_o;
    logic                  ldvio_we_o;

    modport slave (
        input  st_valid_i, st_addr_i, st_age_idx_i,
        output st_ready_o, ldvio_addr_o, ldvio_data_o, ldvio_we_o
    );

    modport master (
        output st_valid_i, st_addr_i, st_age_idx_i,
        input  st_ready_o, ldvio_addr_o, ldvio_data_o, ldvio_we_o
    );
endinterface

// File: rtl/ldvio_writer_prio_pick.sv
// Circular priority encoder (oldest-first from base) plus the load-queue age-window mask.
module ldvio_prio_pick
    import ldvio_writer_pkg::*;
(
    input  lqVector_t vec,
    input  lqIdx_t    base,
    output logic      found,
    output lqIdx_t    index,
    input  lqIdx_t    win_lo,
    input  lqIdx_t    win_hi,
    output lqVector_t win_mask
);
    lqIdx_t slot;
    lqIdx_t win_len;
    lqIdx_t offset;

    // Scan youngest-to-oldest so the last hit left standing is the oldest.
    always_comb begin
        found = 1'b0;
        index = base;
        slot  = '0;
        for (int k = LQ_DEPTH - 1; k >= 0; k--) begin
            slot = base + lqIdx_t'(k);
            if (vec[slot]) begin
                found = 1'b1;
                index = slot;
            end
        end
    end

    always_comb begin
        win_mask = '0;
        win_len  = win_hi - win_lo;
        offset   = '0;
        for (int j = 0; j < LQ_DEPTH; j++) begin
            offset      = lqIdx_t'(j) - win_lo;
            win_mask[j] = (offset < win_len);
        end
    end
endmodule

// File: rtl/ldvio_writer.sv
// Load-violation flag writer: executed-load CAM, store search, one-per-cycle flag drain.
// Optional LDVIO_COUNT_EN adds a saturating count of flag writes.
module ldvio_writer
    import ldvio_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  ld_disp_valid_i,
    input  lqIdx_t                ld_disp_idx_i,
    input  logic                  ld_exec_valid_i,
    input  lqIdx_t                ld_exec_idx_i,
    input  logic [ADDR_WIDTH-1:0] ld_exec_addr_i,
    input  lqIdx_t                lq_tail_i,
    ldvio_writer_if.slave         st_if,
    output logic                  busy_o
`ifdef LDVIO_COUNT_EN
    ,
    output logic [31:0]           ldvio_count_o
`endif
);
    localparam int TAG_W = ADDR_WIDTH - MATCH_LSB;

    lqVector_t    cam_valid;
    logic [TAG_W-1:0] cam_tag [LQ_DEPTH];
    lqVector_t    win_mask, match_vec, disp_mask, pend_eff, pending, pend_nxt;
    ldvio_state_t state, state_nxt;
    lqIdx_t       base, base_nxt, pick_idx, addr_q;
    logic         pick_found, we_nxt, we_q, data_q;
    logic         unused_addr_lsbs;

    assign unused_addr_lsbs = ^{ld_exec_addr_i[MATCH_LSB-1:0], st_if.st_addr_i[MATCH_LSB-1:0]};

    assign disp_mask = ld_disp_valid_i ? (lqVector_t'(1) << ld_disp_idx_i) : '0;
    assign pend_eff  = pending & ~disp_mask;

    ldvio_prio_pick u_pick (
        .vec      (pend_eff),
        .base     (base),
        .found    (pick_found),
        .index    (pick_idx),
        .win_lo   (st_if.st_age_idx_i),
        .win_hi   (lq_tail_i),
        .win_mask (win_mask)
    );

    // Search sees CAM contents from before this cycle's exec/dispatch updates.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            match_vec[i] = cam_valid[i] & win_mask[i] &
                           (cam_tag[i] == st_if.st_addr_i[ADDR_WIDTH-1:MATCH_LSB]);
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pending;
        base_nxt  = base;
        we_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (st_if.st_valid_i) begin
                    // A slot redispatched this cycle holds a new, unexecuted load.
                    pend_nxt  = match_vec & ~disp_mask;
                    base_nxt  = st_if.st_age_idx_i;
                    state_nxt = (pend_nxt != '0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                pend_nxt = pend_eff;
                if (pick_found) begin
                    we_nxt   = 1'b1;
                    pend_nxt = pend_eff & ~(lqVector_t'(1) << pick_idx);
                end
                if (pend_nxt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        base <= base_nxt;
    end

    // Dispatch is written last so it wins a same-slot collision with exec.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            cam_valid <= '0;
        end else begin
            if (ld_exec_valid_i) cam_valid[ld_exec_idx_i] <= 1'b1;
            if (ld_disp_valid_i) cam_valid[ld_disp_idx_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_exec_valid_i) cam_tag[ld_exec_idx_i] <= ld_exec_addr_i[ADDR_WIDTH-1:MATCH_LSB];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            data_q <= 1'b0;
            addr_q <= '0;
        end else if (flush_i) begin
            we_q   <= 1'b0;
            data_q <= 1'b0;
        end else begin
            we_q   <= we_nxt;
            data_q <= we_nxt;
            if (we_nxt) addr_q <= pick_idx;
        end
    end

    assign st_if.ldvio_we_o   = we_q;
    assign st_if.ldvio_data_o = data_q;
    assign st_if.ldvio_addr_o = addr_q;
    assign st_if.st_ready_o   = (state == IDLE);
    assign busy_o             = (state == DRAIN);

`ifdef LDVIO_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)                         count_q <= '0;
        else if (we_q && (count_q != '1))  count_q <= count_q + 32'd1;
    end

    assign ldvio_count_o = count_q;
`endif
endmodule

// File: tb/tb_ldvio_writer.sv
// Bench for ldvio_writer: directed scenarios then random traffic against a slot-list model.
module tb_ldvio_writer;
    import ldvio_writer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset, flush_i, ld_disp_valid_i, ld_exec_valid_i, busy_o;
    lqIdx_t                ld_disp_idx_i, ld_exec_idx_i, lq_tail_i;
    logic [ADDR_WIDTH-1:0] ld_exec_addr_i;
`ifdef LDVIO_COUNT_EN
    logic [31:0]           ldvio_count_o;
`endif

    ldvio_writer_if bus ();

    ldvio_writer dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .ld_disp_valid_i (ld_disp_valid_i),
        .ld_disp_idx_i   (ld_disp_idx_i),
        .ld_exec_valid_i (ld_exec_valid_i),
        .ld_exec_idx_i   (ld_exec_idx_i),
        .ld_exec_addr_i  (ld_exec_addr_i),
        .lq_tail_i       (lq_tail_i),
        .st_if           (bus.slave),
        .busy_o          (busy_o)
`ifdef LDVIO_COUNT_EN
        ,
        .ldvio_count_o   (ldvio_count_o)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference state: which slots hold executed loads, and the ordered list of slots left to flag.
    bit          m_valid [LQ_DEPTH];
    logic [31:0] m_addr  [LQ_DEPTH];
    int          m_q [$];
    bit          m_busy = 1'b0;
    bit          e_we = 1'b0;
    int          e_addr = 0;
    logic [31:0] e_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int win;
        int slot;
        bit we_before;
        we_before = e_we;
        if (reset) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_q.delete();
            m_busy = 1'b0;
            e_we   = 1'b0;
            e_addr = 0;
            e_cnt  = '0;
        end else begin
            if (we_before && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
            e_we = 1'b0;
            if (flush_i) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_q.delete();
                m_busy = 1'b0;
            end else begin
                if (m_busy) begin
                    if (ld_disp_valid_i) begin
                        for (int i = 0; i < m_q.size(); i++) begin
                            if (m_q[i] == int'(ld_disp_idx_i)) begin
                                m_q.delete(i);
                                break;
                            end
                        end
                    end
                    if (m_q.size() > 0) begin
                        e_we   = 1'b1;
                        e_addr = m_q.pop_front();
                    end
                    if (m_q.size() == 0) m_busy = 1'b0;
                end else if (bus.st_valid_i) begin
                    win = (int'(lq_tail_i) - int'(bus.st_age_idx_i) + LQ_DEPTH) % LQ_DEPTH;
                    for (int k = 0; k < win; k++) begin
                        slot = (int'(bus.st_age_idx_i) + k) % LQ_DEPTH;
                        if (m_valid[slot] && ((m_addr[slot] >> MATCH_LSB) == (bus.st_addr_i >> MATCH_LSB))
                            && !(ld_disp_valid_i && int'(ld_disp_idx_i) == slot))
                            m_q.push_back(slot);
                    end
                    m_busy = (m_q.size() > 0);
                end
                if (ld_exec_valid_i) begin
                    m_valid[ld_exec_idx_i] = 1'b1;
                    m_addr[ld_exec_idx_i]  = ld_exec_addr_i;
                end
                if (ld_disp_valid_i) m_valid[ld_disp_idx_i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("we", 32'(bus.ldvio_we_o), 32'(e_we));
        check("addr", 32'(bus.ldvio_addr_o), 32'(e_addr));
        check("ready", 32'(bus.st_ready_o), 32'(!m_busy));
        check("busy", 32'(busy_o), 32'(m_busy));
        if (e_we) check("data", 32'(bus.ldvio_data_o), 32'd1);
`ifdef LDVIO_COUNT_EN
        check("count", ldvio_count_o, e_cnt);
`endif
        reset           = 1'b0;
        flush_i         = 1'b0;
        ld_disp_valid_i = 1'b0;
        ld_exec_valid_i = 1'b0;
        bus.st_valid_i  = 1'b0;
    endtask

    task automatic exec_ld(input int slot, input logic [31:0] addr);
        ld_exec_valid_i = 1'b1;
        ld_exec_idx_i   = lqIdx_t'(slot);
        ld_exec_addr_i  = addr;
        tick();
    endtask

    task automatic search(input logic [31:0] addr, input int age);
        bus.st_valid_i   = 1'b1;
        bus.st_addr_i    = addr;
        bus.st_age_idx_i = lqIdx_t'(age);
        tick();
    endtask

    task automatic expect_write(input string tag, input int slot);
        check({tag, "_we"}, 32'(bus.ldvio_we_o), 32'd1);
        check({tag, "_addr"}, 32'(bus.ldvio_addr_o), 32'(slot));
    endtask

`ifdef LDVIO_COUNT_EN
    logic [31:0] cnt_base;
`endif

    initial begin
        reset = 1'b1; flush_i = 1'b0;
        ld_disp_valid_i = 1'b0; ld_disp_idx_i = '0;
        ld_exec_valid_i = 1'b0; ld_exec_idx_i = '0; ld_exec_addr_i = '0;
        lq_tail_i = '0;
        bus.st_valid_i = 1'b0; bus.st_addr_i = '0; bus.st_age_idx_i = '0;
        tick();
        check("rst_ready", 32'(bus.st_ready_o), 32'd1);
        check("rst_we", 32'(bus.ldvio_we_o), 32'd0);
        check("rst_addr", 32'(bus.ldvio_addr_o), 32'd0);
        check("rst_data", 32'(bus.ldvio_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        // Single match, one-cycle drain.
        exec_ld(3, 32'h1000);
        lq_tail_i = 4'd5;
        search(32'h1002, 2);
        check("t1_ready_low", 32'(bus.st_ready_o), 32'd0);
        tick();
        expect_write("t1", 3);
        check("t1_ready_back", 32'(bus.st_ready_o), 32'd1);

        // Wrap-around ordering 14, 15, 0, 1.
        exec_ld(14, 32'h2000); exec_ld(15, 32'h2000);
        exec_ld(0, 32'h2000);  exec_ld(1, 32'h2000);
        lq_tail_i = 4'd2;
        search(32'h2000, 14);
        tick(); expect_write("t2a", 14);
        tick(); expect_write("t2b", 15);
        tick(); expect_write("t2c", 0);
        tick(); expect_write("t2d", 1);
        tick(); check("t2_done", 32'(bus.ldvio_we_o), 32'd0);

        // Older load and word-mismatch exclusion.
        exec_ld(6, 32'h3000);
        lq_tail_i = 4'd8;
        search(32'h3000, 7);
        check("t3_ready", 32'(bus.st_ready_o), 32'd1);
        tick(); check("t3_old", 32'(bus.ldvio_we_o), 32'd0);
        search(32'h3004, 6);
        tick(); check("t3_word", 32'(bus.ldvio_we_o), 32'd0);

        // Load executing alongside the search is not matched; a later search finds it.
        ld_exec_valid_i = 1'b1; ld_exec_idx_i = 4'd4; ld_exec_addr_i = 32'h4000;
        search(32'h4000, 4);
        tick(); check("t4_same", 32'(bus.ldvio_we_o), 32'd0);
        search(32'h4000, 4);
        tick(); expect_write("t4_next", 4);

        // Dispatch to slot 2 during the first pick removes it from the drain.
        exec_ld(1, 32'h5000); exec_ld(2, 32'h5000); exec_ld(3, 32'h5000);
        lq_tail_i = 4'd4;
        search(32'h5000, 1);
        ld_disp_valid_i = 1'b1; ld_disp_idx_i = 4'd2;
        tick(); expect_write("t5a", 1);
        tick(); expect_write("t5b", 3);
        tick(); check("t5_done", 32'(bus.ldvio_we_o), 32'd0);

        // Flush in the second drain cycle of a four-match search.
`ifdef LDVIO_COUNT_EN
        cnt_base = ldvio_count_o;
`endif
        exec_ld(8, 32'h6000); exec_ld(9, 32'h6000);
        exec_ld(10, 32'h6000); exec_ld(11, 32'h6000);
        lq_tail_i = 4'd12;
        search(32'h6000, 8);
        tick(); expect_write("t6a", 8);
        flush_i = 1'b1;
        tick();
        check("t6_we", 32'(bus.ldvio_we_o), 32'd0);
        check("t6_ready", 32'(bus.st_ready_o), 32'd1);
        search(32'h6000, 8);
        tick(); check("t6_empty", 32'(bus.ldvio_we_o), 32'd0);
`ifdef LDVIO_COUNT_EN
        check("t6_count", ldvio_count_o - cnt_base, 32'd1);
`endif

        // Random traffic over a small address set so matches are frequent.
        for (int n = 0; n < 3000; n++) begin
            ld_exec_valid_i  = ($urandom_range(0, 9) < 4);
            ld_exec_idx_i    = lqIdx_t'($urandom_range(0, LQ_DEPTH - 1));
            ld_exec_addr_i   = 32'h7000 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            ld_disp_valid_i  = ($urandom_range(0, 9) < 2);
            ld_disp_idx_i    = lqIdx_t'($urandom_range(0, LQ_DEPTH - 1));
            if ($urandom_range(0, 7) == 0) lq_tail_i = lqIdx_t'($urandom_range(0, LQ_DEPTH - 1));
            bus.st_valid_i   = ($urandom_range(0, 9) < 3);
            bus.st_addr_i    = 32'h7000 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            bus.st_age_idx_i = lqIdx_t'($urandom_range(0, LQ_DEPTH - 1));
            flush_i          = ($urandom_range(0, 99) < 2);
            reset            = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ldvio_writer.md
Name: ldvio_writer

Overview:
- Write-side producer for the load-violation flag RAM in the load/store queue.
- Keeps a small address CAM of executed loads, indexed by load-queue slot.
- When a store resolves its address, searches that CAM for younger executed loads to the same word.
- Drains every match, one per cycle, through the flag RAM's single write port (addr/data/we).
- Dispatch-side readers pick the flags up at commit.

Parameters:
- LQ_DEPTH, 16, load-queue entries (power of two)
- LQ_INDEX, 4, log2(LQ_DEPTH)
- ADDR_WIDTH, 32, load/store effective-address width
- MATCH_LSB, 2, low address bits ignored in compare (word granularity)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush_i  in  1  pipeline recovery; clears all state
- ld_disp_valid_i  in  1  load dispatched into slot; invalidates that CAM entry
- ld_disp_idx_i  in  LQ_INDEX  dispatched slot
- ld_exec_valid_i  in  1  load executed; records its address
- ld_exec_idx_i  in  LQ_INDEX  executed slot
- ld_exec_addr_i  in  ADDR_WIDTH  load address
- lq_tail_i  in  LQ_INDEX  next free load slot (exclusive youngest bound)
- st_valid_i  in  1  store address resolved, search request
- st_ready_o  out  1  search request can be accepted
- st_addr_i  in  ADDR_WIDTH  store address
- st_age_idx_i  in  LQ_INDEX  oldest load slot younger than the store
- ldvio_addr_o  out  LQ_INDEX  flag-RAM write index
- ldvio_data_o  out  1  flag-RAM write data, always 1 when we asserted
- ldvio_we_o  out  1  flag-RAM write enable
- busy_o  out  1  drain in progress

Behaviour:
- Reset: all CAM valid bits 0, pending vector 0, state IDLE. Outputs: st_ready_o=1, ldvio_we_o=0, ldvio_addr_o=0, ldvio_data_o=0, busy_o=0.
- CAM entry i holds valid + address[ADDR_WIDTH-1:MATCH_LSB].
  - Exec write sets valid[i]=1 and stores the address.
  - Dispatch clears valid[i].
  - If both target the same slot in one cycle, dispatch wins.
- Age window: slot j is younger than the store when (j - st_age_idx_i) mod LQ_DEPTH < (lq_tail_i - st_age_idx_i) mod LQ_DEPTH. If st_age_idx_i == lq_tail_i the window is empty and no match is possible.
- Match vector: valid & age window & address-field equality. It uses CAM contents before this cycle's exec/dispatch updates, so a load executing in the same cycle as a search is not matched (the load itself reads the store data).
- State machine: IDLE and DRAIN.
  - IDLE: st_ready_o=1. On st_valid_i, pending <= match vector and the search base <= st_age_idx_i. Enter DRAIN if match is nonzero; otherwise stay IDLE.
  - DRAIN: st_ready_o=0, busy_o=1. Each cycle, pick the first pending bit in circular order from the search base (oldest first).
    - Registered outputs: ldvio_we_o=1, ldvio_addr_o=slot, ldvio_data_o=1 in the next cycle.
    - Clear that pending bit. When pending becomes 0, return to IDLE in the same edge.
  - Latency: search accepted at edge T, first write visible after T+1, k matches produce writes on k consecutive cycles. st_ready_o returns after the last pick.
- Dispatch into a slot with its pending bit set clears that pending bit; that slot produces no write. If this empties pending, go to IDLE.
- ldvio_we_o is low every cycle without a pick; ldvio_addr_o holds its last value.
- flush_i: at the edge, clear all valid and pending bits and go to IDLE. ldvio_we_o=0 in the following cycle. flush_i has priority over every other input.
- Reset mid-drain behaves like flush and also returns outputs to their reset values.

Optional Feature:
- Macro LDVIO_COUNT_EN.
- When defined: adds output ldvio_count_o (32 bits). It increments by 1 per asserted ldvio_we_o, saturates at all-ones, clears on reset only (not on flush).
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared LSQ package: LQ_DEPTH/LQ_INDEX constants, the lqVector_t typedef (LQ_DEPTH-bit vector) and the ldvio_state_t enum {IDLE, DRAIN}.
- One sub-module, ldvio_prio_pick: combinational circular priority encoder (vector, base) -> (found, index). The same module computes the age-window mask helper.

Test Plan:
- Reset, then exec slot 3 at 0x1000, tail=5; store at 0x1002, age_idx=2 -> one write: addr 3, data 1, one cycle after acceptance; st_ready_o low exactly 1 cycle.
- Exec slots 14, 15, 0, 1 at 0x2000, tail=2; store 0x2000, age_idx=14 -> writes 14, 15, 0, 1 on four consecutive cycles (wrap-around ordering).
- Exec slot 6 at 0x3000, tail=8; store 0x3000, age_idx=7 -> no write, st_ready_o stays 1 (older load excluded); repeat with address 0x3004 and age_idx=6 -> no write (word mismatch).
- Exec slot 4 at the same cycle as a store search at the same address, age_idx=4 -> no write; the next search at that address writes slot 4.
- Drain of slots 1, 2, 3 with dispatch to slot 2 during the first pick cycle -> writes only 1 and 3.
- Flush asserted in the second drain cycle of a 4-match search -> ldvio_we_o 0 next cycle, st_ready_o 1, a new search finds no matches; with LDVIO_COUNT_EN the count equals the writes issued before the flush.
